// File: rtl/apb_master.sv
// APB4 requester engine: takes one command, runs the SETUP/ACCESS phases,
// and returns the read data and error status on a valid/ready response port.
module apb_master #(
  parameter int addrWidth = 32,
  parameter int dataWidth = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [addrWidth-1:0]   cmd_addr,
  input  logic [dataWidth-1:0]   cmd_wdata,
  input  logic [dataWidth/8-1:0] cmd_strb,
  input  logic [2:0]             cmd_prot,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [dataWidth-1:0]   rsp_rdata,
  output logic                   rsp_slverr,
  output logic [2:0]             pprot,
  output logic                   pselx,
  output logic                   penable,
  output logic                   pwrite,
  output logic [dataWidth/8-1:0] pstrb,
  output logic [addrWidth-1:0]   paddr,
  output logic [dataWidth-1:0]   pwdata,
  input  logic                   pslverr,
  input  logic                   pready,
  input  logic [dataWidth-1:0]   prdata
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_t;

  state_t state;
  state_t state_nxt;

  logic accept;
  logic done;

  assign accept = (state == IDLE) && cmd_valid;
  assign done   = (state == ACCESS) && pready;

  assign cmd_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (cmd_valid) state_nxt = SETUP;
      SETUP:  state_nxt = ACCESS;
      ACCESS: if (pready) state_nxt = RESP;
      RESP:   if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Select/enable come straight from flops, loaded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      pselx   <= 1'b0;
      penable <= 1'b0;
    end else begin
      pselx   <= (state_nxt == SETUP) || (state_nxt == ACCESS);
      penable <= (state_nxt == ACCESS);
    end
  end

  // Request fields persist after the transfer until the next accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      paddr  <= '0;
      pwrite <= 1'b0;
      pwdata <= '0;
      pstrb  <= '0;
      pprot  <= '0;
    end else if (accept) begin
      paddr  <= cmd_addr;
      pwrite <= cmd_write;
      pwdata <= cmd_write ? cmd_wdata : '0;
      pstrb  <= cmd_write ? cmd_strb : '0;
      pprot  <= cmd_prot;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_rdata  <= '0;
      rsp_slverr <= 1'b0;
    end else if (done) begin
      rsp_rdata  <= pwrite ? '0 : prdata;
      rsp_slverr <= pslverr;
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a transfer-level model.
module tb_apb_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  logic [2:0]  cmd_prot;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_slverr;
  logic [2:0]  pprot;
  logic        pselx;
  logic        penable;
  logic        pwrite;
  logic [3:0]  pstrb;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic        pslverr;
  logic        pready;
  logic [31:0] prdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  apb_master #(.addrWidth(32), .dataWidth(32)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
    .pprot(pprot), .pselx(pselx), .penable(penable),
    .pwrite(pwrite), .pstrb(pstrb), .paddr(paddr),
    .pwdata(pwdata), .pslverr(pslverr),
    .pready(pready), .prdata(prdata)
  );

  task automatic chk(input string name,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h t=%0t",
               name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] s,
                     input logic [2:0] p);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_strb  = s;
    cmd_prot  = p;
  endtask

  // Transfer-level model: a transfer is in flight from accept until the
  // response handshake; it spends one cycle in setup, then waits for pready.
  logic        m_on = 1'b0;
  logic        busy, in_setup, got_rsp;
  logic        ex_write;
  logic [31:0] ex_addr, ex_wdata, ex_rdata;
  logic [3:0]  ex_strb;
  logic [2:0]  ex_prot;
  logic        ex_err;

  always @(posedge clk) begin
    if (rst) begin
      m_on     <= 1'b1;
      busy     <= 1'b0;
      in_setup <= 1'b0;
      got_rsp  <= 1'b0;
      ex_write <= 1'b0;
      ex_addr  <= '0;
      ex_wdata <= '0;
      ex_strb  <= '0;
      ex_prot  <= '0;
      ex_rdata <= '0;
      ex_err   <= 1'b0;
    end else if (!busy) begin
      if (cmd_valid) begin
        busy     <= 1'b1;
        in_setup <= 1'b1;
        got_rsp  <= 1'b0;
        ex_write <= cmd_write;
        ex_addr  <= cmd_addr;
        ex_wdata <= cmd_write ? cmd_wdata : 32'h0;
        ex_strb  <= cmd_write ? cmd_strb : 4'h0;
        ex_prot  <= cmd_prot;
      end
    end else if (in_setup) begin
      in_setup <= 1'b0;
    end else if (!got_rsp) begin
      if (pready) begin
        got_rsp  <= 1'b1;
        ex_rdata <= ex_write ? 32'h0 : prdata;
        ex_err   <= pslverr;
      end
    end else if (rsp_ready) begin
      busy    <= 1'b0;
      got_rsp <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      chk("m_cmd_ready", cmd_ready, !busy);
      chk("m_rsp_valid", rsp_valid, busy && got_rsp);
      chk("m_pselx", pselx, busy && !got_rsp);
      chk("m_penable", penable, busy && !got_rsp && !in_setup);
      chk("m_paddr", paddr, ex_addr);
      chk("m_pwrite", pwrite, ex_write);
      chk("m_pwdata", pwdata, ex_wdata);
      chk("m_pstrb", pstrb, ex_strb);
      chk("m_pprot", pprot, ex_prot);
      chk("m_rsp_rdata", rsp_rdata, ex_rdata);
      chk("m_rsp_slverr", rsp_slverr, ex_err);
    end
  end

  initial begin
    int pen;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr = '0;
    cmd_wdata = '0;
    cmd_strb = '0;
    cmd_prot = '0;
    rsp_ready = 1'b0;
    pslverr = 1'b0;
    pready = 1'b0;
    prdata = '0;
    step();
    step();
    rst = 1'b0;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_pselx", pselx, 0);
    chk("rst_penable", penable, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_pstrb", pstrb, 0);

    // zero-wait write; pready high during setup must be ignored
    cmd(1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 4'hF, 3'b010);
    pready = 1'b1;
    step();
    cmd_valid = 1'b0;
    chk("wr_setup_psel", pselx, 1);
    chk("wr_setup_pen", penable, 0);
    chk("wr_setup_ready", cmd_ready, 0);
    step();
    chk("wr_acc_pen", penable, 1);
    chk("wr_acc_paddr", paddr, 32'h0000_1004);
    chk("wr_acc_pwdata", pwdata, 32'hDEAD_BEEF);
    chk("wr_acc_pstrb", pstrb, 4'hF);
    chk("wr_acc_pprot", pprot, 3'b010);
    step();
    chk("wr_rsp_valid", rsp_valid, 1);
    chk("wr_rsp_psel", pselx, 0);
    chk("wr_rsp_err", rsp_slverr, 0);
    chk("wr_rsp_rdata", rsp_rdata, 0);
    rsp_ready = 1'b1;
    pready = 1'b0;
    step();
    rsp_ready = 1'b0;
    chk("wr_idle_ready", cmd_ready, 1);
    chk("wr_idle_rsp", rsp_valid, 0);

    // read, three wait states; pslverr/prdata junk while not ready
    cmd(1'b0, 32'h40, 32'hFFFF_FFFF, 4'hF, 3'b000);
    step();
    cmd_valid = 1'b0;
    chk("rd_pstrb", pstrb, 0);
    chk("rd_pwdata", pwdata, 0);
    step();
    pen = 0;
    for (int i = 0; i < 4; i++) begin
      if (penable) pen++;
      pready  = (i == 3);
      prdata  = (i == 3) ? 32'h1234_5678 : 32'hBAD0_0000 + i;
      pslverr = (i < 3);
      step();
    end
    pready = 1'b0;
    pslverr = 1'b0;
    chk("rd_pen_cycles", pen, 4);
    chk("rd_rsp_valid", rsp_valid, 1);
    chk("rd_rsp_rdata", rsp_rdata, 32'h1234_5678);
    chk("rd_rsp_err", rsp_slverr, 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // completer error
    cmd(1'b0, 32'h80, 32'h0, 4'h0, 3'b001);
    pready = 1'b1;
    pslverr = 1'b1;
    prdata = 32'hA5A5_A5A5;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    chk("err_rsp_valid", rsp_valid, 1);
    chk("err_slverr", rsp_slverr, 1);
    chk("err_rdata", rsp_rdata, 32'hA5A5_A5A5);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    pslverr = 1'b0;
    chk("err_idle", cmd_ready, 1);

    // backpressure with a second command waiting
    cmd(1'b1, 32'h200, 32'h1111_2222, 4'h3, 3'b000);
    step();
    cmd(1'b1, 32'h300, 32'h3333_4444, 4'hC, 3'b101);
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_cmd_ready", cmd_ready, 0);
      chk("bp_paddr", paddr, 32'h200);
      step();
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("bp_idle_ready", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
    chk("bp_2nd_psel", pselx, 1);
    chk("bp_2nd_paddr", paddr, 32'h300);
    chk("bp_2nd_pprot", pprot, 3'b101);
    step();
    step();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // reset during access
    cmd(1'b1, 32'h500, 32'h5555_5555, 4'hF, 3'b000);
    pready = 1'b0;
    step();
    cmd_valid = 1'b0;
    step();
    chk("ra_penable", penable, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("ra_pselx", pselx, 0);
    chk("ra_penable0", penable, 0);
    chk("ra_ready", cmd_ready, 1);
    pready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("ra_no_rsp", rsp_valid, 0);
      step();
    end

    // random traffic, model checks every cycle
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 299) == 0);
      cmd_valid = ($urandom_range(0, 2) != 0);
      cmd_write = $urandom_range(0, 1);
      cmd_addr  = $urandom;
      cmd_wdata = $urandom;
      cmd_strb  = 4'($urandom);
      cmd_prot  = 3'($urandom);
      pready    = ($urandom_range(0, 2) == 0);
      pslverr   = $urandom_range(0, 1);
      prdata    = $urandom;
      rsp_ready = $urandom_range(0, 1);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
